// File: rtl/spi_ram_master.sv
// spi_ram_master: turns parallel host read/write requests into the SPI RAM slave's
// two-frame command protocol. Define SPI_RAM_MASTER_ADDR_SKIP_EN for address caching.
module spi_ram_master #(
  parameter int RD_WAIT  = 1,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_TURN    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  localparam logic [3:0] GAP_LOAD  = 4'(IDLE_GAP - 1);
  localparam logic [3:0] TURN_LOAD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

  logic [2:0]  state_r;
  logic        rd_r;
  logic [7:0]  addr_r;
  logic [7:0]  wdata_r;
  logic        data_phase_r;
  logic [3:0]  bit_cnt_r;
  logic [3:0]  wait_cnt_r;
  logic [7:0]  shift_r;
  logic [7:0]  rdata_r;
  logic        done_r;
  logic        busy_r;
  logic        ss_n_r;
  logic        mosi_r;
  logic        accept_s;
  logic        skip_s;
  logic [7:0]  byte_s;
  logic [10:0] frame_s;

  assign req_ready = (state_r == ST_IDLE);
  assign accept_s  = req_valid && (state_r == ST_IDLE);
  assign done      = done_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign SS_n      = ss_n_r;
  assign MOSI      = mosi_r;

`ifdef SPI_RAM_MASTER_ADDR_SKIP_EN
  logic [7:0] wr_addr_r;
  logic [7:0] rd_addr_r;
  logic       wr_vld_r;
  logic       rd_vld_r;

  // Address-frame skip when the request hits the cache of its own direction
  always_comb begin
    skip_s = 1'b0;
    if (req_rd) begin
      skip_s = rd_vld_r && (rd_addr_r == req_addr);
    end else begin
      skip_s = wr_vld_r && (wr_addr_r == req_addr);
    end
  end

  // Last-address caches, refreshed on every accept
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_r <= 8'h00;
      rd_addr_r <= 8'h00;
      wr_vld_r  <= 1'b0;
      rd_vld_r  <= 1'b0;
    end else if (accept_s) begin
      if (req_rd) begin
        rd_addr_r <= req_addr;
        rd_vld_r  <= 1'b1;
      end else begin
        wr_addr_r <= req_addr;
        wr_vld_r  <= 1'b1;
      end
    end
  end
`else
  assign skip_s = 1'b0;
`endif

  // Frame under transmission: {cmd[1], cmd[1:0], byte}
  always_comb begin
    byte_s = 8'h00;
    if (!data_phase_r) begin
      byte_s = addr_r;
    end else if (rd_r) begin
      byte_s = 8'h00;
    end else begin
      byte_s = wdata_r;
    end
    frame_s = {rd_r, rd_r, data_phase_r, byte_s};
  end

  // Transaction sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rd_r         <= 1'b0;
      addr_r       <= 8'h00;
      wdata_r      <= 8'h00;
      data_phase_r <= 1'b0;
      bit_cnt_r    <= 4'd0;
      wait_cnt_r   <= 4'd0;
      shift_r      <= 8'h00;
      rdata_r      <= 8'h00;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= accept_s ? 1'b1 : (done_r ? 1'b0 : busy_r);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            rd_r         <= req_rd;
            addr_r       <= req_addr;
            wdata_r      <= req_wdata;
            data_phase_r <= skip_s;
            state_r      <= ST_START;
          end
        end
        ST_START: begin
          bit_cnt_r <= 4'd10;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_cnt_r == 4'd0) begin
            if (rd_r && data_phase_r) begin
              if (RD_WAIT == 0) begin
                bit_cnt_r <= 4'd7;
                state_r   <= ST_CAPTURE;
              end else begin
                wait_cnt_r <= TURN_LOAD;
                state_r    <= ST_TURN;
              end
            end else begin
              wait_cnt_r <= GAP_LOAD;
              state_r    <= ST_GAP;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r - 4'd1;
          end
        end
        ST_TURN: begin
          if (wait_cnt_r == 4'd0) begin
            bit_cnt_r <= 4'd7;
            state_r   <= ST_CAPTURE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_CAPTURE: begin
          shift_r <= {shift_r[6:0], MISO};
          if (bit_cnt_r == 4'd0) begin
            wait_cnt_r <= GAP_LOAD;
            state_r    <= ST_GAP;
          end else begin
            bit_cnt_r <= bit_cnt_r - 4'd1;
          end
        end
        ST_GAP: begin
          if (wait_cnt_r != 4'd0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end else if (!data_phase_r) begin
            data_phase_r <= 1'b1;
            state_r      <= ST_START;
          end else begin
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
            if (rd_r) begin
              rdata_r <= shift_r;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Serial pins, registered from the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_r <= 1'b1;
      mosi_r <= 1'b0;
    end else begin
      ss_n_r <= !((state_r == ST_START) || (state_r == ST_SHIFT) ||
                  (state_r == ST_TURN)  || (state_r == ST_CAPTURE));
      mosi_r <= (state_r == ST_SHIFT) ? frame_s[bit_cnt_r] : 1'b0;
    end
  end

endmodule
